pipe_hazard_ctrl: RTL

- Sequences the ID2EXE pipeline register and the stages around it: PC, IF/ID and ID/EXE.
- Detects load-use hazards, branch-taken flushes and multicycle EXE operations.
- Drives hold, flush and bubble controls so that ID/EXE receives zeroed control fields (WB/M/EXE = 0) whenever the instruction in ID must not advance.
- Sits beside the ID stage.
- Inputs come from ID decode, the ID/EXE register outputs and EXE branch resolution.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_cmp.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard controller.
// Imported by hazard_cmp and pipe_hazard_ctrl.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MC_WAIT  = 2'd2,
    FLUSH    = 2'd3
  } hz_state_t;

  localparam int REG_W = 5;
  localparam int CNT_W = 32;

  localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/hazard_cmp.sv
// Load-use comparator: ID sources against the ID/EXE destination.
// Purely combinational; also usable by forwarding logic.
module hazard_cmp
  import hazard_pkg::*;
(
  input  logic             mem_read,
  input  logic             valid,
  input  logic [REG_W-1:0] dest,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             src2_valid,
  output logic             hit
);

  logic m1;
  logic m2;

  assign m1  = (dest == src1);
  assign m2  = src2_valid & (dest == src2);
  assign hit = mem_read & valid & (dest != ZERO_REG) & (m1 | m2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hold/flush/bubble sequencer for PC, IF/ID and ID/EXE.
// Optional perf counters: define HAZ_PERF_EN.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MC_TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_src2_valid,
  input  logic             id_mc_start,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             br_taken,
  input  logic             mc_done,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             mc_busy,
  output logic             hz_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] FL_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TO_MAX  = 8'(MC_TIMEOUT);
  localparam bit         FL_MULT = (FLUSH_CYCLES > 1);

  hz_state_t  state, state_nxt;
  logic [2:0] fcnt, fcnt_nxt;
  logic [7:0] tcnt, tcnt_nxt, tcnt_inc;
  logic       lu;
  logic       hold, flush, bubble, busy;
  logic       err_set;

  hazard_cmp u_cmp (
    .mem_read   (ex_mem_read),
    .valid      (id_valid),
    .dest       (ex_dest),
    .src1       (id_src1),
    .src2       (id_src2),
    .src2_valid (id_src2_valid),
    .hit        (lu)
  );

  assign tcnt_inc = (tcnt == 8'hff) ? tcnt : tcnt + 8'd1;

  // Next state and Mealy controls from state plus current inputs
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    tcnt_nxt  = tcnt;
    hold      = 1'b0;
    flush     = 1'b0;
    bubble    = 1'b0;
    busy      = 1'b0;
    err_set   = 1'b0;
    unique case (state)
      RUN, LU_STALL: begin
        state_nxt = RUN;
        if (br_taken) begin
          flush  = 1'b1;
          bubble = 1'b1;
          fcnt_nxt = FL_LOAD;
          if (FL_MULT) state_nxt = FLUSH;
        end else if (state == RUN && lu) begin
          hold      = 1'b1;
          bubble    = 1'b1;
          state_nxt = LU_STALL;
        end else if (state == RUN && id_mc_start && id_valid) begin
          tcnt_nxt  = '0;
          state_nxt = MC_WAIT;
        end
      end
      FLUSH: begin
        flush  = 1'b1;
        bubble = 1'b1;
        if (br_taken) begin
          fcnt_nxt = FL_LOAD;
        end else if (fcnt <= 3'd1) begin
          fcnt_nxt  = '0;
          state_nxt = RUN;
        end else begin
          fcnt_nxt = fcnt - 3'd1;
        end
      end
      MC_WAIT: begin
        if (br_taken) err_set = 1'b1;
        if (mc_done) begin
          state_nxt = RUN;
        end else begin
          hold     = 1'b1;
          bubble   = 1'b1;
          busy     = 1'b1;
          tcnt_nxt = tcnt_inc;
          if (tcnt_inc >= TO_MAX) begin
            err_set   = 1'b1;
            state_nxt = RUN;
          end
        end
      end
    endcase
  end

  // State, flush/timeout counters and sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= RUN;
      fcnt   <= '0;
      tcnt   <= '0;
      hz_err <= 1'b0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
      tcnt  <= tcnt_nxt;
      if (err_set) hz_err <= 1'b1;
    end
  end

  assign pc_hold     = rst & hold;
  assign ifid_hold   = rst & hold;
  assign ifid_flush  = rst & flush;
  assign idex_bubble = rst & bubble;
  assign mc_busy     = rst & busy;

`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  // Count held and flushed cycles, wrapping naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (pc_hold)    stall_q <= stall_q + 1'b1;
      if (ifid_flush) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
